bus_traffic_checker: RTL

Synthesizable self-checking traffic generator that drives one `master_port` device interface (`dwdata/drdata/daddr/dvalid/dready/dmode`) in place of bench stimulus. It issues pseudo-random write/read transactions to a configurable set of slave devices on `bus_m2_s3` (local slaves or bus-bridge slaves), compares read-back data, and reports pass/fail, error count and first-failure details. Used for on-board soak testing and as a reusable bench driver.

---
 rtl/bus_traffic_checker.sv | 313 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/bus_traffic_checker.sv
// Self-checking traffic generator for a master_port device interface: issues
// LFSR-driven write/read transactions to enabled bus devices and checks the read-back data.
module bus_traffic_checker #(
  parameter int                              ADDR_WIDTH           = 16,
  parameter int                              DATA_WIDTH           = 8,
  parameter int                              SLAVE_MEM_ADDR_WIDTH = 13,
  parameter int                              NUM_TARGETS          = 3,
  parameter int                              ITERATIONS           = 5,
  parameter logic [SLAVE_MEM_ADDR_WIDTH-1:0] OFFSET_MASK          = 13'h7FF,
  parameter logic [15:0]                     LFSR_SEED            = 16'hACE1,
  parameter int                              TIMEOUT_CYCLES       = 200000
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   mode_sel,
  input  logic [NUM_TARGETS-1:0] target_mask,
  output logic [DATA_WIDTH-1:0]  dwdata,
  output logic [ADDR_WIDTH-1:0]  daddr,
  output logic                   dmode,
  output logic                   dvalid,
  input  logic                   dready,
  input  logic [DATA_WIDTH-1:0]  drdata,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout,
  output logic                   cfg_err,
  output logic [7:0]             err_count,
  output logic [15:0]            txn_count,
  output logic [ADDR_WIDTH-1:0]  fail_addr,
  output logic [DATA_WIDTH-1:0]  fail_exp,
  output logic [DATA_WIDTH-1:0]  fail_act
);

  localparam int TW = ADDR_WIDTH - SLAVE_MEM_ADDR_WIDTH;
  localparam int OW = SLAVE_MEM_ADDR_WIDTH;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 8);
  localparam logic [7:0] LAST_ITEM = 8'(ITERATIONS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GEN, S_GAP, S_ISSUE, S_WAIT_ACC, S_WAIT_CMP, S_CHECK, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic [15:0]            snap_q, snap_d;
  logic [OW-1:0]          base_q, base_d;
  logic [NUM_TARGETS-1:0] mask_q, mask_d;
  logic                   mode_q, mode_d;
  logic [TW-1:0]          tgt_q, tgt_d;
  logic [7:0]             item_q, item_d;
  logic                   rd_phase_q, rd_phase_d;
  logic [2:0]             gap_q, gap_d;
  logic [CW-1:0]          wait_cnt_q, wait_cnt_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [ADDR_WIDTH-1:0]  daddr_q, daddr_d;
  logic                   dmode_q, dmode_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [7:0]             err_q, err_d;
  logic [15:0]            txn_q, txn_d;
  logic [ADDR_WIDTH-1:0]  fail_addr_q, fail_addr_d;
  logic [DATA_WIDTH-1:0]  fail_exp_q, fail_exp_d;
  logic [DATA_WIDTH-1:0]  fail_act_q, fail_act_d;
  logic                   timeout_q, timeout_d;
  logic                   cfg_err_q, cfg_err_d;

  logic [15:0]            lfsr_a, lfsr_b, seed_step;
  logic [OW-1:0]          offset_gen;
  logic [NUM_TARGETS-1:0] above_mask;
  logic [TW-1:0]          first_tgt, next_tgt;
  logic                   wait_expired;
  logic                   advance;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [TW-1:0] lowest_set(input logic [NUM_TARGETS-1:0] v);
    logic [TW-1:0] r;
    r = '0;
    for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
      if (v[i]) r = TW'(i);
    end
    return r;
  endfunction

  assign lfsr_a    = lfsr_step(lfsr_q);
  assign lfsr_b    = lfsr_step(lfsr_a);
  assign seed_step = lfsr_step(LFSR_SEED);

  // Block mode walks consecutive offsets from a per-run base so every address is unique.
  assign offset_gen = mode_q ? ((base_q + OW'(item_q)) & OFFSET_MASK)
                             : (lfsr_b[OW-1:0] & OFFSET_MASK);

  for (genvar gi = 0; gi < NUM_TARGETS; gi++) begin : g_above
    assign above_mask[gi] = mask_q[gi] & (tgt_q < TW'(gi));
  end

  assign first_tgt    = lowest_set(mask_q);
  assign next_tgt     = (|above_mask) ? lowest_set(above_mask) : first_tgt;
  assign wait_expired = (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    snap_d      = snap_q;
    base_d      = base_q;
    mask_d      = mask_q;
    mode_d      = mode_q;
    tgt_d       = tgt_q;
    item_d      = item_q;
    rd_phase_d  = rd_phase_q;
    gap_d       = gap_q;
    data_d      = data_q;
    daddr_d     = daddr_q;
    dmode_d     = dmode_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    txn_d       = txn_q;
    fail_addr_d = fail_addr_q;
    fail_exp_d  = fail_exp_q;
    fail_act_d  = fail_act_q;
    timeout_d   = timeout_q;
    cfg_err_d   = cfg_err_q;
    advance     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          err_d       = '0;
          txn_d       = '0;
          fail_addr_d = '0;
          fail_exp_d  = '0;
          fail_act_d  = '0;
          timeout_d   = 1'b0;
          cfg_err_d   = 1'b0;
          if (|target_mask) begin
            // The base draw is taken every run so both modes share one LFSR schedule.
            lfsr_d     = seed_step;
            snap_d     = seed_step;
            base_d     = seed_step[OW-1:0];
            mask_d     = target_mask;
            mode_d     = mode_sel;
            tgt_d      = lowest_set(target_mask);
            item_d     = '0;
            rd_phase_d = 1'b0;
            state_d    = S_GEN;
          end else begin
            cfg_err_d = 1'b1;
            state_d   = S_DONE;
          end
        end
      end

      S_GEN: begin
        lfsr_d  = lfsr_b;
        data_d  = lfsr_a[DATA_WIDTH-1:0];
        gap_d   = lfsr_b[2:0];
        daddr_d = {tgt_q, offset_gen};
        dmode_d = ~rd_phase_q;
        state_d = S_GAP;
      end

      S_GAP: begin
        if ((wait_cnt_q >= CW'(gap_q)) && dready) begin
          state_d = S_ISSUE;
        end else if (wait_expired) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
      end

      S_ISSUE: begin
        if (wait_cnt_q == CW'(1)) state_d = S_WAIT_ACC;
      end

      S_WAIT_ACC: begin
        if (!dready) begin
          state_d = S_WAIT_CMP;
        end else if (wait_expired) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
      end

      S_WAIT_CMP: begin
        if (dready) begin
          txn_d = txn_q + 16'd1;
          if (!dmode_q) begin
            rdata_d = drdata;
            state_d = S_CHECK;
          end else if (!mode_q) begin
            rd_phase_d = 1'b1;
            dmode_d    = 1'b0;
            state_d    = S_GAP;
          end else begin
            advance = 1'b1;
          end
        end else if (wait_expired) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
      end

      S_CHECK: begin
        if (rdata_q != data_q) begin
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          if (err_q == 8'd0) begin
            fail_addr_d = daddr_q;
            fail_exp_d  = data_q;
            fail_act_d  = rdata_q;
          end
        end
        advance = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase

    // End of an item: move to the next target, replay the write schedule, or finish.
    if (advance) begin
      if (item_q == LAST_ITEM) begin
        if (mode_q && !rd_phase_q) begin
          lfsr_d     = snap_q;
          tgt_d      = first_tgt;
          item_d     = '0;
          rd_phase_d = 1'b1;
          state_d    = S_GEN;
        end else begin
          state_d = S_DONE;
        end
      end else begin
        item_d = item_q + 8'd1;
        tgt_d  = next_tgt;
        if (!mode_q) rd_phase_d = 1'b0;
        state_d = S_GEN;
      end
    end

    if ((state_d != state_q) || (state_q == S_IDLE) || (state_q == S_DONE)) begin
      wait_cnt_d = '0;
    end else begin
      wait_cnt_d = wait_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      snap_q      <= LFSR_SEED;
      base_q      <= '0;
      mask_q      <= '0;
      mode_q      <= 1'b0;
      tgt_q       <= '0;
      item_q      <= '0;
      rd_phase_q  <= 1'b0;
      gap_q       <= '0;
      wait_cnt_q  <= '0;
      data_q      <= '0;
      daddr_q     <= '0;
      dmode_q     <= 1'b0;
      rdata_q     <= '0;
      err_q       <= '0;
      txn_q       <= '0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_act_q  <= '0;
      timeout_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      snap_q      <= snap_d;
      base_q      <= base_d;
      mask_q      <= mask_d;
      mode_q      <= mode_d;
      tgt_q       <= tgt_d;
      item_q      <= item_d;
      rd_phase_q  <= rd_phase_d;
      gap_q       <= gap_d;
      wait_cnt_q  <= wait_cnt_d;
      data_q      <= data_d;
      daddr_q     <= daddr_d;
      dmode_q     <= dmode_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      txn_q       <= txn_d;
      fail_addr_q <= fail_addr_d;
      fail_exp_q  <= fail_exp_d;
      fail_act_q  <= fail_act_d;
      timeout_q   <= timeout_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign dvalid    = (state_q == S_ISSUE);
  assign dwdata    = data_q;
  assign daddr     = daddr_q;
  assign dmode     = dmode_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign pass      = done && (err_q == 8'd0) && !timeout_q && !cfg_err_q;
  assign timeout   = timeout_q;
  assign cfg_err   = cfg_err_q;
  assign err_count = err_q;
  assign txn_count = txn_q;
  assign fail_addr = fail_addr_q;
  assign fail_exp  = fail_exp_q;
  assign fail_act  = fail_act_q;

endmodule
